memory_control: RTL and testbench
=================================

MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum consecutive non-ACCESS RAM cycles tolerated per transaction.
REQ-002 Parameter: STARVE_MAX, 4, maximum consecutive data grants while iREN is pending.
REQ-003 Clocking: one clock; reset is asynchronous and active-low; ports are named CLK and nRST.
REQ-004 Port: CLK  in  1  system clock; all state updates on the rising edge.
REQ-005 Port: nRST  in  1  asynchronous active-low reset.
REQ-006 Port: iREN  in  1  instruction-cache read request.
REQ-007 Port: iaddr  in  32  instruction-cache word address.
REQ-008 Port: iwait  out  1  low for exactly the completing cycle of an instruction read.
REQ-009 Port: iload  out  32  instruction read data, valid when iwait is low.
REQ-010 Port: dREN  in  1  data-cache read request.
REQ-011 Port: dWEN  in  1  data-cache write request.
REQ-012 Port: daddr  in  32  data-cache word address.
REQ-013 Port: dstore  in  32  data-cache write data.
REQ-014 Port: dwait  out  1  low for exactly the completing cycle of a data read or write.
REQ-015 Port: dload  out  32  data read data, valid when dwait is low.
REQ-016 Port: ramREN  out  1  RAM read enable.
REQ-017 Port: ramWEN  out  1  RAM write enable.
REQ-018 Port: ramaddr  out  32  RAM address.
REQ-019 Port: ramstore  out  32  RAM write data.
REQ-020 Port: ramload  in  32  RAM read data.
REQ-021 Port: ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-022 Port: memerr  out  1  sticky error flag, set by RAM ERROR or timeout.

Function
REQ-023 The FSM SHALL have states IDLE, IREAD, DREAD, and DWRITE, held in a register.
REQ-024 In IDLE, grant priority SHALL be dWEN, then dREN, then iREN; the granted address and store data are latched and the FSM enters the matching state on the next edge.
REQ-025 If iREN has been pending through STARVE_MAX consecutive data grants, the next grant SHALL go to iREN; the starvation counter clears on any instruction grant or whenever iREN is low.
REQ-026 If dREN and dWEN are both high, the request SHALL be treated as a write.
REQ-027 In IREAD and DREAD, ramREN SHALL be 1; in DWRITE, ramWEN SHALL be 1; ramaddr and ramstore SHALL come from the latched registers; in IDLE, all RAM outputs SHALL be 0.
REQ-028 When ramstate is ACCESS in a serving state, the requester's wait SHALL be driven low combinationally that cycle, load SHALL equal ramload for reads, and the FSM returns to IDLE.
REQ-029 Minimum latency: request in cycle N, completion in cycle N+1 if RAM returns ACCESS immediately; there is a mandatory IDLE cycle between transactions.
REQ-030 When ramstate is ERROR in a serving state, the transaction SHALL complete as for ACCESS, with load forced to 32'hBAD1BAD1 for reads, and memerr is set.
REQ-031 A 16-bit watchdog SHALL count serving cycles without ACCESS or ERROR; when it reaches TIMEOUT, the transaction completes as for ERROR.
REQ-032 The watchdog SHALL clear on every entry to IDLE.
REQ-033 If the granted request deasserts before completion, the FSM SHALL return to IDLE on the next edge without lowering wait and without setting memerr.
REQ-034 Outside its completing cycle, iwait and dwait SHALL each be 1, and iload and dload SHALL each be 0.
REQ-035 iwait and dwait SHALL never be low in the same cycle.
REQ-036 memerr SHALL clear only on reset.

Reset
REQ-037 While nRST is low, the FSM SHALL be IDLE; iwait=1 and dwait=1; iload, dload, ramREN, ramWEN, ramaddr, and ramstore SHALL be 0; all counters and latches SHALL be 0; memerr=0.
REQ-038 Reset asserted mid-transaction SHALL abort that transaction immediately with no completion pulse.

Verification
REQ-039 Scenario: dREN with daddr=0x40, ramstate ACCESS, ramload=0x12345678 -> ramREN=1, ramaddr=0x40 next cycle; dwait=0 for one cycle with dload=0x12345678.
REQ-040 Scenario: iREN and dWEN raised together, dstore=0xCAFE -> DWRITE is served first with ramWEN=1; IREAD follows after one IDLE cycle; iwait and dwait are never low together.
REQ-041 Scenario: iREN held while dREN is re-requested continuously -> after 4 data grants, the 5th grant is IREAD.
REQ-042 Scenario: ramstate held BUSY for a read -> after 16 cycles, completion with load=0xBAD1BAD1 and memerr=1, sticky until nRST.
REQ-043 Scenario: ramstate ERROR during DWRITE -> dwait=0 one cycle and memerr=1.
REQ-044 Scenario: nRST pulsed low during BUSY in DREAD -> outputs take reset values immediately; no dwait pulse occurs.

Source files
------------

// File: rtl/memory_control_if.sv
// ---------------------------------------------------------------------------
// memory_control_if
// Bundles every signal exchanged by the memory controller with the caches and
// the RAM. Clock and reset are deliberately kept out of the bundle.
//
// Cache side : iREN/iaddr -> iwait/iload        (instruction read channel)
//              dREN/dWEN/daddr/dstore -> dwait/dload  (data read/write channel)
// RAM side   : ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate
// Status     : memerr (sticky error flag)
//
// Modports:
//   slave  - the controller's view (consumes requests, drives RAM + waits)
//   master - the environment's view (caches and RAM together)
// ---------------------------------------------------------------------------
interface memory_control_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        memerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               memerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               memerr
    );
endinterface

// File: rtl/memory_control.sv
// ---------------------------------------------------------------------------
// memory_control
// Arbitrates one shared RAM between an instruction cache and a data cache.
// Data writes beat data reads beat instruction reads, except that an
// instruction read that has been passed over STARVE_MAX times in a row wins
// the next grant. Each transaction latches its address/store data, drives the
// RAM until it reports ACCESS or ERROR (or the watchdog expires), pulses the
// requester's wait low for that one completing cycle, then returns to IDLE.
//
// Ports:
//   CLK   - system clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - memory_control_if.slave (cache request/response + RAM bus +
//           sticky memerr)
// Parameters:
//   TIMEOUT    - non-ACCESS/ERROR serving cycles tolerated before the
//                transaction is forced to complete as an error
//   STARVE_MAX - consecutive data grants tolerated while iREN is pending
// ---------------------------------------------------------------------------
module memory_control #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input logic              CLK,
    input logic              nRST,
    memory_control_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IREAD  = 2'd1;
    localparam logic [1:0] DREAD  = 2'd2;
    localparam logic [1:0] DWRITE = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [31:0] ERR_WORD    = 32'hBAD1BAD1;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    localparam logic [15:0] STARVE_LIM  = 16'(STARVE_MAX);

    logic [1:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] store_q,  store_d;
    logic [15:0] wd_q,     wd_d;
    logic [15:0] starve_q, starve_d;
    logic        memerr_q, memerr_d;

    logic        serving;
    logic        req_live;
    logic        timed_out;
    logic        complete;
    logic        err_complete;
    logic [31:0] rdata;

    // Completion decode. A request that drops while being served is an
    // abort: it never completes, so it can neither pulse wait nor flag an
    // error. The watchdog only fires on cycles where the RAM itself has not
    // already answered.
    always_comb begin
        serving  = (state_q != IDLE);
        req_live = 1'b0;
        case (state_q)
            IREAD:   req_live = bus.iREN;
            DREAD:   req_live = bus.dREN;
            DWRITE:  req_live = bus.dWEN;
            default: req_live = 1'b0;
        endcase
        timed_out    = (bus.ramstate != RAM_ACCESS) &&
                       (bus.ramstate != RAM_ERROR) &&
                       (wd_q >= TIMEOUT_LIM);
        complete     = serving && req_live &&
                       ((bus.ramstate == RAM_ACCESS) ||
                        (bus.ramstate == RAM_ERROR) || timed_out);
        err_complete = serving && req_live &&
                       ((bus.ramstate == RAM_ERROR) || timed_out);
        rdata        = err_complete ? ERR_WORD : bus.ramload;
    end

    // Next-state logic: grant arbitration in IDLE, completion/abort while
    // serving. The starvation counter counts data grants that overtook a
    // pending iREN and is wiped the moment iREN goes away.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wd_d     = wd_q;
        starve_d = starve_q;
        memerr_d = memerr_q | err_complete;

        case (state_q)
            IDLE: begin
                wd_d = 16'd0;
                if (bus.iREN && (starve_q >= STARVE_LIM)) begin
                    state_d  = IREAD;
                    addr_d   = bus.iaddr;
                    store_d  = 32'd0;
                    starve_d = 16'd0;
                end else if (bus.dWEN) begin
                    state_d  = DWRITE;
                    addr_d   = bus.daddr;
                    store_d  = bus.dstore;
                    starve_d = starve_q + 16'd1;
                end else if (bus.dREN) begin
                    state_d  = DREAD;
                    addr_d   = bus.daddr;
                    store_d  = 32'd0;
                    starve_d = starve_q + 16'd1;
                end else if (bus.iREN) begin
                    state_d  = IREAD;
                    addr_d   = bus.iaddr;
                    store_d  = 32'd0;
                    starve_d = 16'd0;
                end
            end
            default: begin
                if (complete || !req_live) begin
                    state_d = IDLE;
                    wd_d    = 16'd0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
        endcase

        if (!bus.iREN) begin
            starve_d = 16'd0;
        end
    end

    // State registers; reset drops everything back to IDLE at once, which
    // kills any in-flight transaction without a completion pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            wd_q     <= 16'd0;
            starve_q <= 16'd0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wd_q     <= wd_d;
            starve_q <= starve_d;
            memerr_q <= memerr_d;
        end
    end

    // RAM bus is silent in IDLE; waits/loads are decoded from the single
    // current state, so only one side can ever complete in a given cycle.
    // memerr includes the completing error cycle so it rises with the pulse.
    assign bus.ramREN   = (state_q == IREAD) || (state_q == DREAD);
    assign bus.ramWEN   = (state_q == DWRITE);
    assign bus.ramaddr  = serving ? addr_q  : 32'd0;
    assign bus.ramstore = serving ? store_q : 32'd0;

    assign bus.iwait = !((state_q == IREAD) && complete);
    assign bus.iload = ((state_q == IREAD) && complete) ? rdata : 32'd0;
    assign bus.dwait = !(((state_q == DREAD) || (state_q == DWRITE)) && complete);
    assign bus.dload = ((state_q == DREAD) && complete) ? rdata : 32'd0;

    assign bus.memerr = memerr_q | err_complete;

endmodule

// File: tb/tb_memory_control.sv
// ---------------------------------------------------------------------------
// tb_memory_control
// Directed scenarios for memory_control. The stimulus process pushes the
// expected completion (side, load, memerr, cycle) into a queue; a monitor on
// the falling edge pops and compares whenever a wait goes low.
// ---------------------------------------------------------------------------
module tb_memory_control;

    typedef struct {
        bit          isData;
        logic [31:0] load;
        bit          memerr;
        int          cycle;
        int          tag;
    } exp_t;

    logic CLK;
    logic nRST;
    int   cyc;
    int   checks;
    int   errors;
    exp_t expQ[$];

    memory_control_if bus();

    memory_control #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle counter: the value seen after a rising edge names that cycle.
    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Drive every request/RAM input in one go.
    task automatic applyStimulus(input logic i_ren, input logic [31:0] i_addr,
                                 input logic d_ren, input logic d_wen,
                                 input logic [31:0] d_addr, input logic [31:0] d_store,
                                 input logic [1:0] r_state, input logic [31:0] r_load);
        bus.iREN     = i_ren;
        bus.iaddr    = i_addr;
        bus.dREN     = d_ren;
        bus.dWEN     = d_wen;
        bus.daddr    = d_addr;
        bus.dstore   = d_store;
        bus.ramstate = r_state;
        bus.ramload  = r_load;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, want);
        end
    endtask

    task automatic pushExp(input bit isData, input logic [31:0] load,
                           input bit memerr, input int cycle, input int tag);
        exp_t e;
        e.isData = isData;
        e.load   = load;
        e.memerr = memerr;
        e.cycle  = cycle;
        e.tag    = tag;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares each completion pulse against the scoreboard head,
    // and checks that loads stay zero and waits never drop together.
    always @(negedge CLK) begin
        exp_t e;
        if (!bus.iwait && !bus.dwait) begin
            checks++;
            errors++;
            $display("[TB] FAIL both_waits_low cyc=%0d", cyc);
        end
        if (!bus.iwait || !bus.dwait) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_completion cyc=%0d iwait=%b dwait=%b required no pulse",
                         cyc, bus.iwait, bus.dwait);
            end else begin
                e = expQ.pop_front();
                if ((e.isData != !bus.dwait) ||
                    (e.load !== (e.isData ? bus.dload : bus.iload)) ||
                    (e.memerr != bus.memerr) || (e.cycle != cyc)) begin
                    errors++;
                    $display("[TB] FAIL completion_tag%0d got data=%b load=%h memerr=%b cyc=%0d required data=%b load=%h memerr=%b cyc=%0d",
                             e.tag, !bus.dwait, (e.isData ? bus.dload : bus.iload),
                             bus.memerr, cyc, e.isData, e.load, e.memerr, e.cycle);
                end
            end
        end else begin
            checks++;
            if ((bus.iload !== 32'd0) || (bus.dload !== 32'd0)) begin
                errors++;
                $display("[TB] FAIL idle_loads cyc=%0d got iload=%h dload=%h required 0",
                         cyc, bus.iload, bus.dload);
            end
        end
    end

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed scenarios.
    initial begin
        int c;
        checks = 0;
        errors = 0;
        nRST   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);

        // Reset values
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rst_iwait", {31'd0, bus.iwait}, 32'd1);
        checkOutput("rst_dwait", {31'd0, bus.dwait}, 32'd1);
        checkOutput("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        checkOutput("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        checkOutput("rst_ramaddr", bus.ramaddr, 32'd0);
        checkOutput("rst_ramstore", bus.ramstore, 32'd0);
        checkOutput("rst_memerr", {31'd0, bus.memerr}, 32'd0);
        tick();
        nRST = 1'b1;
        tick();

        // Data read, RAM answers immediately
        c = cyc;
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 2'd2, 32'h12345678);
        pushExp(1, 32'h12345678, 0, c + 1, 1);
        tick();
        @(negedge CLK);
        checkOutput("s1_ramREN", {31'd0, bus.ramREN}, 32'd1);
        checkOutput("s1_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        checkOutput("s1_ramaddr", bus.ramaddr, 32'h40);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();

        // Write and instruction read together: write first, then IREAD
        c = cyc;
        applyStimulus(1, 32'h100, 0, 1, 32'h80, 32'hCAFE, 2'd2, 32'h11112222);
        pushExp(1, 32'h0, 0, c + 1, 2);
        pushExp(0, 32'h11112222, 0, c + 3, 3);
        tick();
        @(negedge CLK);
        checkOutput("s2_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        checkOutput("s2_ramaddr", bus.ramaddr, 32'h80);
        checkOutput("s2_ramstore", bus.ramstore, 32'hCAFE);
        tick();
        bus.dWEN = 1'b0;
        @(negedge CLK);
        checkOutput("s2_gap_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        tick();
        @(negedge CLK);
        checkOutput("s2_iaddr", bus.ramaddr, 32'h100);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();

        // Starvation: four data grants, then the instruction read wins
        c = cyc;
        applyStimulus(1, 32'h600, 1, 0, 32'h500, 0, 2'd2, 32'h0A0A0A0A);
        for (int k = 0; k < 4; k++) pushExp(1, 32'h0A0A0A0A, 0, c + 1 + 2 * k, 4 + k);
        pushExp(0, 32'h0A0A0A0A, 0, c + 9, 8);
        repeat (9) tick();
        @(negedge CLK);
        checkOutput("s3_iaddr", bus.ramaddr, 32'h600);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();

        // Watchdog: RAM stuck BUSY on a data read
        c = cyc;
        applyStimulus(0, 0, 1, 0, 32'h200, 0, 2'd1, 32'h55555555);
        pushExp(1, 32'hBAD1BAD1, 1, c + 17, 9);
        @(negedge CLK);
        checkOutput("s4_memerr_before", {31'd0, bus.memerr}, 32'd0);
        repeat (18) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();
        tick();
        @(negedge CLK);
        checkOutput("s4_memerr_sticky", {31'd0, bus.memerr}, 32'd1);
        tick();

        // Reset pulse while DREAD is BUSY: immediate abort, no pulse
        applyStimulus(0, 0, 1, 0, 32'h400, 0, 2'd1, 32'h77777777);
        tick();
        @(negedge CLK);
        checkOutput("s6_ramREN_busy", {31'd0, bus.ramREN}, 32'd1);
        tick();
        nRST = 1'b0;
        #1;
        checkOutput("s6_dwait", {31'd0, bus.dwait}, 32'd1);
        checkOutput("s6_ramREN", {31'd0, bus.ramREN}, 32'd0);
        checkOutput("s6_ramaddr", bus.ramaddr, 32'd0);
        checkOutput("s6_memerr", {31'd0, bus.memerr}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();
        nRST = 1'b1;
        tick();

        // Request dropped mid-transaction: silent return to IDLE
        applyStimulus(0, 0, 1, 0, 32'h700, 0, 2'd1, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd1, 0);
        @(negedge CLK);
        checkOutput("ab_memerr", {31'd0, bus.memerr}, 32'd0);
        tick();
        @(negedge CLK);
        checkOutput("ab_ramREN", {31'd0, bus.ramREN}, 32'd0);
        tick();

        // RAM ERROR on a write (dREN and dWEN both set -> write)
        c = cyc;
        applyStimulus(0, 0, 1, 1, 32'h300, 32'hDEADBEEF, 2'd3, 32'h99999999);
        pushExp(1, 32'h0, 1, c + 1, 10);
        tick();
        @(negedge CLK);
        checkOutput("s5_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        checkOutput("s5_ramREN", {31'd0, bus.ramREN}, 32'd0);
        checkOutput("s5_ramstore", bus.ramstore, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 0);
        tick();
        @(negedge CLK);
        checkOutput("s5_memerr_sticky", {31'd0, bus.memerr}, 32'd1);

        // Drain: every expected completion must have been seen
        for (int i = 0; i < 50 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_completion got pending=%0d required 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
